xcorr_frame_scheduler: RTL and testbench



---
 rtl/xcorr_frame_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_xcorr_frame_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/xcorr_frame_scheduler.sv
// Window/hop trigger sequencer for the cross-correlation datapath: snapshots all lag
// vectors at each trigger, scans them serially for the peak, and hands the lags downstream.
module xcorr_frame_scheduler #(
  parameter int NUM_SAMPLES       = 100,
  parameter int HOP_SAMPLES       = 100,
  parameter int MAX_SAMPLES_DELAY = 11,
  parameter int NUM_XCORRS        = 6,
  parameter int NUM_BITS_XCORR    = 31,
  parameter int SETTLE_CYCLES     = 1,
  parameter int LAG_BITS          = $clog2(2*MAX_SAMPLES_DELAY+1)+1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  validIn,
  input  logic [NUM_XCORRS*(2*MAX_SAMPLES_DELAY+1)*NUM_BITS_XCORR-1:0] xCorrIn,
  output logic [NUM_XCORRS*LAG_BITS-1:0]                        lagOut,
  output logic [NUM_XCORRS*NUM_BITS_XCORR-1:0]                  peakOut,
  output logic                                                  lagValid,
  input  logic                                                  lagReady,
  output logic                                                  busy,
  output logic                                                  overrun
);

  localparam int NLAGS = 2*MAX_SAMPLES_DELAY+1;
  localparam int TOTAL = NUM_XCORRS*NLAGS;
  localparam int VEC_W = TOTAL*NUM_BITS_XCORR;
  localparam int CNT_W = $clog2(NUM_SAMPLES+1);
  localparam int HOP_W = $clog2(HOP_SAMPLES+1);
  localparam int SET_W = $clog2(SETTLE_CYCLES+1);
  localparam int J_W   = $clog2(NLAGS);
  localparam int I_W   = $clog2(NUM_XCORRS+1);
  localparam int K_W   = $clog2(TOTAL+1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES-1);
  localparam logic [HOP_W-1:0] HOP_LAST = HOP_W'(HOP_SAMPLES-1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES-1);
  localparam logic [J_W-1:0]   J_LAST   = J_W'(NLAGS-1);
  localparam logic [I_W-1:0]   I_LAST   = I_W'(NUM_XCORRS-1);
  localparam logic [LAG_BITS-1:0] LAG_OFS = LAG_BITS'(MAX_SAMPLES_DELAY);

  localparam logic [2:0] S_FILL   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SNAP   = 3'd3;
  localparam logic [2:0] S_SCAN   = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  logic [2:0]                          state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [HOP_W-1:0]                    hop_q, hop_d;
  logic [SET_W-1:0]                    settle_q, settle_d;
  logic [VEC_W-1:0]                    snap_q, snap_d;
  logic [I_W-1:0]                      i_q, i_d;
  logic [J_W-1:0]                      j_q, j_d, jbest_q, jbest_d;
  logic [K_W-1:0]                      k_q, k_d;
  logic signed [NUM_BITS_XCORR-1:0]    best_q, best_d;
  logic [NUM_XCORRS*LAG_BITS-1:0]      lag_q, lag_d;
  logic [NUM_XCORRS*NUM_BITS_XCORR-1:0] peak_q, peak_d;
  logic                                valid_q, valid_d, busy_q, busy_d, overrun_q, overrun_d;

  logic                                filled_s, trig_s, busy_state_s, last_j_s, last_s;
  logic signed [NUM_BITS_XCORR-1:0]    entry_s, cand_best_s;
  logic [J_W-1:0]                      cand_j_s;
  logic [LAG_BITS-1:0]                 lag_val_s;

  assign filled_s     = (cnt_q == CNT_FULL);
  assign trig_s       = validIn && ((!filled_s && (cnt_q == CNT_LAST)) ||
                                    (filled_s && (hop_q == HOP_LAST)));
  assign busy_state_s = (state_q != S_FILL) && (state_q != S_IDLE);
  assign entry_s      = snap_q[k_q*NUM_BITS_XCORR +: NUM_BITS_XCORR];
  assign last_j_s     = (j_q == J_LAST);
  assign last_s       = last_j_s && (i_q == I_LAST);

  // Running peak: j=0 seeds the search, later entries replace only on strictly greater.
  always_comb begin
    if ((j_q == '0) || (entry_s > best_q)) begin
      cand_best_s = entry_s;
      cand_j_s    = j_q;
    end else begin
      cand_best_s = best_q;
      cand_j_s    = jbest_q;
    end
    lag_val_s = {{(LAG_BITS-J_W){1'b0}}, cand_j_s} - LAG_OFS;
  end

  // Next-state logic for counters, FSM, scan datapath and outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hop_d    = hop_q;
    settle_d = settle_q;
    snap_d   = snap_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    best_d   = best_q;
    jbest_d  = jbest_q;
    lag_d    = lag_q;
    peak_d   = peak_q;

    if (validIn) begin
      if (!filled_s) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (hop_q == HOP_LAST) begin
        hop_d = '0;
      end else begin
        hop_d = hop_q + HOP_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_FILL, S_IDLE: begin
        if (trig_s) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d = S_SNAP;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_SNAP: begin
        snap_d  = xCorrIn;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        best_d  = cand_best_s;
        jbest_d = cand_j_s;
        k_d     = k_q + K_W'(1);
        if (last_j_s) begin
          j_d = '0;
          i_d = i_q + I_W'(1);
          lag_d[i_q*LAG_BITS +: LAG_BITS]             = lag_val_s;
          peak_d[i_q*NUM_BITS_XCORR +: NUM_BITS_XCORR] = cand_best_s;
        end else begin
          j_d = j_q + J_W'(1);
        end
        if (last_s) begin
          state_d = S_OUT;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_OUT: begin
        if (lagReady) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_FILL;
    endcase

    overrun_d = trig_s && busy_state_s;
    valid_d   = (state_d == S_OUT);
    busy_d    = (state_d != S_FILL) && (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILL;
      cnt_q     <= '0;
      hop_q     <= '0;
      settle_q  <= '0;
      snap_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      best_q    <= '0;
      jbest_q   <= '0;
      lag_q     <= '0;
      peak_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hop_q     <= hop_d;
      settle_q  <= settle_d;
      snap_q    <= snap_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      best_q    <= best_d;
      jbest_q   <= jbest_d;
      lag_q     <= lag_d;
      peak_q    <= peak_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign lagOut   = lag_q;
  assign peakOut  = peak_q;
  assign lagValid = valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_xcorr_frame_scheduler.sv
// Directed bench for xcorr_frame_scheduler: default instance plus a HOP_SAMPLES=1 instance
// (short window) for the overrun scenario.
module tb_xcorr_frame_scheduler;
  localparam int NB = 31;
  localparam int NL = 23;
  localparam int NX = 6;
  localparam int LB = 6;
  localparam int VW = NX*NL*NB;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst, validIn, lagReady, validIn1, lagReady1;
  logic [VW-1:0] xc;
  logic [NX*LB-1:0] lag0, lag1;
  logic [NX*NB-1:0] peak0, peak1;
  logic lv0, busy0, ov0, lv1, busy1, ov1;

  int checks = 0;
  int errors = 0;
  logic signed [LB-1:0] exp_lag  [NX];
  logic signed [NB-1:0] exp_peak [NX];

  xcorr_frame_scheduler dut (
    .clk(clk), .rst(rst), .validIn(validIn), .xCorrIn(xc),
    .lagOut(lag0), .peakOut(peak0), .lagValid(lv0), .lagReady(lagReady),
    .busy(busy0), .overrun(ov0)
  );

  xcorr_frame_scheduler #(.NUM_SAMPLES(4), .HOP_SAMPLES(1)) dut1 (
    .clk(clk), .rst(rst), .validIn(validIn1), .xCorrIn(xc),
    .lagOut(lag1), .peakOut(peak1), .lagValid(lv1), .lagReady(lagReady1),
    .busy(busy1), .overrun(ov1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input int i, input int j, input logic signed [NB-1:0] v);
    xc[(i*NL+j)*NB +: NB] = v;
  endtask

  // Hand-built vectors: each pair exercises a different peak position or tie rule.
  task automatic load_table;
    for (int j = 0; j < NL; j++) begin
      set_e(0, j, 31'sd0);
      set_e(1, j, 31'sd0);
      set_e(2, j, 31'sd0);
      set_e(3, j, -31'sd100);
      set_e(4, j, -31'sd1000);
      set_e(5, j, 31'sh40000000);
    end
    set_e(0, 14, 31'sd5000);
    set_e(2, 4, 31'sd700);
    set_e(2, 20, 31'sd700);
    set_e(3, 0, -31'sd3);
    set_e(4, 22, -31'sd1);
    set_e(5, 11, 31'sh3FFFFFFF);
    exp_lag[0] = 6'sd3;    exp_peak[0] = 31'sd5000;
    exp_lag[1] = -6'sd11;  exp_peak[1] = 31'sd0;
    exp_lag[2] = -6'sd7;   exp_peak[2] = 31'sd700;
    exp_lag[3] = -6'sd11;  exp_peak[3] = -31'sd3;
    exp_lag[4] = 6'sd11;   exp_peak[4] = -31'sd1;
    exp_lag[5] = 6'sd0;    exp_peak[5] = 31'sh3FFFFFFF;
  endtask

  task automatic test_reset;
    rst = 1'b1; validIn = 1'b0; lagReady = 1'b0; validIn1 = 1'b0; lagReady1 = 1'b0;
    xc = '0;
    tick; tick;
    rst = 1'b0;
    checks++; if (lag0 !== '0)  begin errors++; $display("FAIL reset_lag got %h exp 0", lag0); end
    checks++; if (peak0 !== '0) begin errors++; $display("FAIL reset_peak got %h exp 0", peak0); end
    checks++; if ({lv0, busy0, ov0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {lv0, busy0, ov0}); end
    checks++; if ({lv1, busy1, ov1} !== 3'b000) begin errors++; $display("FAIL reset_flags1 got %b exp 000", {lv1, busy1, ov1}); end
  endtask

  task automatic test_fill;
    int bad;
    int n;
    load_table();
    bad = 0;
    for (int s = 0; s < 99; s++) begin
      validIn = 1'b1; tick; validIn = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (busy0 !== 1'b0 || lv0 !== 1'b0) bad++;
        if (c < 3) tick;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_quiet got %0d bad cycles exp 0", bad); end
    validIn = 1'b1; tick; validIn = 1'b0;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL fill_busy got %b exp 1", busy0); end
    n = 0;
    while (lv0 !== 1'b1 && n < 300) begin tick; n++; end
    checks++; if (n !== 140) begin errors++; $display("FAIL fill_latency got %0d exp 140", n); end
  endtask

  task automatic test_peaks;
    for (int p = 0; p < NX; p++) begin
      checks++;
      if ($signed(lag0[p*LB +: LB]) !== exp_lag[p]) begin
        errors++; $display("FAIL peaks_lag[%0d] got %0d exp %0d", p, $signed(lag0[p*LB +: LB]), exp_lag[p]);
      end
      checks++;
      if ($signed(peak0[p*NB +: NB]) !== exp_peak[p]) begin
        errors++; $display("FAIL peaks_val[%0d] got %0d exp %0d", p, $signed(peak0[p*NB +: NB]), exp_peak[p]);
      end
    end
  endtask

  task automatic test_hold;
    logic [NX*LB-1:0] lsave;
    logic [NX*NB-1:0] psave;
    int bad;
    lsave = lag0; psave = peak0; bad = 0;
    lagReady = 1'b0;
    xc = ~xc;
    for (int c = 0; c < 50; c++) begin
      tick;
      if (lv0 !== 1'b1 || busy0 !== 1'b1 || lag0 !== lsave || peak0 !== psave) bad++;
    end
    load_table();
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles exp 0", bad); end
    lagReady = 1'b1; tick; lagReady = 1'b0;
    checks++; if ({lv0, busy0} !== 2'b00) begin errors++; $display("FAIL hold_handshake got %b exp 00", {lv0, busy0}); end
    tick;
    checks++; if (lag0 !== lsave || peak0 !== psave) begin errors++; $display("FAIL hold_retain got %h exp %h", lag0, lsave); end
  endtask

  task automatic test_overrun;
    int n;
    int ovc;
    validIn1 = 1'b1;
    tick; tick; tick;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL ovr_prefill got %b exp 0", busy1); end
    tick;
    checks++; if ({busy1, ov1} !== 2'b10) begin errors++; $display("FAIL ovr_trigger got %b exp 10", {busy1, ov1}); end
    n = 0; ovc = 0;
    while (lv1 !== 1'b1 && n < 300) begin
      tick; n++;
      if (ov1 === 1'b1) ovc++;
      if (n == 10) xc = '0;
    end
    checks++; if (n !== 140) begin errors++; $display("FAIL ovr_latency got %0d exp 140", n); end
    checks++; if (ovc !== 140) begin errors++; $display("FAIL ovr_pulses got %0d exp 140", ovc); end
    for (int p = 0; p < NX; p++) begin
      checks++;
      if ($signed(lag1[p*LB +: LB]) !== exp_lag[p] || $signed(peak1[p*NB +: NB]) !== exp_peak[p]) begin
        errors++; $display("FAIL ovr_result[%0d] got %0d/%0d exp %0d/%0d", p,
                           $signed(lag1[p*LB +: LB]), $signed(peak1[p*NB +: NB]), exp_lag[p], exp_peak[p]);
      end
    end
    lagReady1 = 1'b1; tick; lagReady1 = 1'b0;
    checks++; if ({lv1, busy1, ov1} !== 3'b001) begin errors++; $display("FAIL ovr_handshake got %b exp 001", {lv1, busy1, ov1}); end
    tick;
    checks++; if ({busy1, ov1} !== 2'b10) begin errors++; $display("FAIL ovr_accept got %b exp 10", {busy1, ov1}); end
    validIn1 = 1'b0;
    load_table();
  endtask

  task automatic test_back_to_back_reset;
    int bad;
    int n;
    bad = 0;
    validIn = 1'b1;
    for (int s = 0; s < 99; s++) begin tick; if (busy0 !== 1'b0) bad++; end
    tick;
    checks++; if (bad !== 0) begin errors++; $display("FAIL hop_quiet got %0d bad cycles exp 0", bad); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL hop_trigger got %b exp 1", busy0); end
    validIn = 1'b0;
    for (int c = 0; c < 75; c++) tick;
    rst = 1'b1; tick; rst = 1'b0;
    checks++; if (lag0 !== '0 || peak0 !== '0) begin errors++; $display("FAIL midrst_data got %h/%h exp 0", lag0, peak0); end
    checks++; if ({lv0, busy0, ov0} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b exp 000", {lv0, busy0, ov0}); end
    bad = 0;
    validIn = 1'b1;
    for (int s = 0; s < 99; s++) begin tick; if (busy0 !== 1'b0 || lv0 !== 1'b0) bad++; end
    tick; validIn = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL refill_quiet got %0d bad cycles exp 0", bad); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL refill_trigger got %b exp 1", busy0); end
    n = 0;
    while (lv0 !== 1'b1 && n < 300) begin tick; n++; end
    checks++; if (n !== 140) begin errors++; $display("FAIL refill_latency got %0d exp 140", n); end
    for (int p = 0; p < NX; p++) begin
      checks++;
      if ($signed(lag0[p*LB +: LB]) !== exp_lag[p]) begin
        errors++; $display("FAIL refill_lag[%0d] got %0d exp %0d", p, $signed(lag0[p*LB +: LB]), exp_lag[p]);
      end
    end
    lagReady = 1'b1; tick; lagReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_peaks();
    test_hold();
    test_overrun();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
